// File: rtl/sfifo_sync_if.sv
// ============================================================================
// Module   : sfifo_sync_if
// Brief    : Push/pop handshake bundle for the single-clock FIFO.
//            The SFIFO_SYNC_ERR_EN macro adds err_clr/ovf/udf.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sfifo_sync_if #(
   parameter int DW = 24,
   parameter int AW = 4
);
   logic          push;
   logic [DW-1:0] data_in;
   logic          full;
   logic          alFull;
   logic          pop;
   logic          vld;
   logic [DW-1:0] data_out;
   logic          empty;
   logic          alEmpty;
   logic [AW:0]   count;
`ifdef SFIFO_SYNC_ERR_EN
   logic          err_clr;
   logic          ovf;
   logic          udf;
`endif

   modport master (
      output push, data_in, pop,
`ifdef SFIFO_SYNC_ERR_EN
      output err_clr,
      input  ovf, udf,
`endif
      input  full, alFull, vld, data_out, empty, alEmpty, count
   );

   modport slave (
      input  push, data_in, pop,
`ifdef SFIFO_SYNC_ERR_EN
      input  err_clr,
      output ovf, udf,
`endif
      output full, alFull, vld, data_out, empty, alEmpty, count
   );
endinterface

`default_nettype wire

// File: rtl/sfifo_sync.sv
// ============================================================================
// Module   : sfifo_sync
// Brief    : Single-clock FIFO, 2^AW x DW, one-cycle read latency, registered
//            flags. Define SFIFO_SYNC_ERR_EN for sticky ovf/udf error flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sfifo_sync #(
   parameter int DW       = 24,
   parameter int AW       = 4,
   parameter int HEADROOM = 2,
   parameter int LOWROOM  = 2
) (
   input  wire logic    clk,
   input  wire logic    rst_n,
   sfifo_sync_if.slave  bus
);

   localparam int          c_DEPTH  = 1 << AW;
   localparam logic [AW:0] c_FULL_V = (AW+1)'(c_DEPTH);
   // Out-of-range thresholds are clamped so the flags saturate instead of wrapping.
   localparam logic [AW:0] c_AF_TH  = (HEADROOM >= c_DEPTH) ? '0 : (AW+1)'(c_DEPTH - HEADROOM);
   localparam logic [AW:0] c_AE_TH  = (LOWROOM  >= c_DEPTH) ? c_FULL_V : (AW+1)'(LOWROOM);
   localparam logic        c_AF_RST = (HEADROOM >= c_DEPTH) ? 1'b1 : 1'b0;

   logic [DW-1:0] r_mem [c_DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_full;
   logic          r_alfull;
   logic          r_empty;
   logic          r_alempty;
   logic          r_vld;
   logic [DW-1:0] r_data_out;

   logic          w_push_ok;
   logic          w_pop_ok;
   logic [AW:0]   w_cnt_nxt;

   assign w_push_ok = bus.push & ~r_full;
   assign w_pop_ok  = bus.pop  & ~r_empty;
   assign w_cnt_nxt = r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);

   // Storage is not reset; only entries between the pointers are meaningful.
   always_ff @(posedge clk) begin
      if (w_push_ok)
         r_mem[r_wr_ptr[AW-1:0]] <= bus.data_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_alfull   <= c_AF_RST;
         r_empty    <= 1'b1;
         r_alempty  <= 1'b1;
         r_vld      <= 1'b0;
         r_data_out <= '0;
      end else begin
         if (w_push_ok)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_data_out <= r_mem[r_rd_ptr[AW-1:0]];
         end
         r_vld     <= w_pop_ok;
         r_count   <= w_cnt_nxt;
         // Flags follow the next-state count so they never see push/pop combinationally.
         r_full    <= (w_cnt_nxt == c_FULL_V);
         r_alfull  <= (w_cnt_nxt >= c_AF_TH);
         r_empty   <= (w_cnt_nxt == '0);
         r_alempty <= (w_cnt_nxt <= c_AE_TH);
      end
   end

   assign bus.full     = r_full;
   assign bus.alFull   = r_alfull;
   assign bus.empty    = r_empty;
   assign bus.alEmpty  = r_alempty;
   assign bus.count    = r_count;
   assign bus.vld      = r_vld;
   assign bus.data_out = r_data_out;

`ifdef SFIFO_SYNC_ERR_EN
   logic r_ovf;
   logic r_udf;

   // A new error in the same cycle as err_clr wins, so no event is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         r_ovf <= (bus.push & r_full)  | (r_ovf & ~bus.err_clr);
         r_udf <= (bus.pop  & r_empty) | (r_udf & ~bus.err_clr);
      end
   end

   assign bus.ovf = r_ovf;
   assign bus.udf = r_udf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sfifo_sync.sv
// ============================================================================
// Module   : tb_sfifo_sync
// Brief    : Directed self-checking bench for sfifo_sync (DW=24, AW=4, HEADROOM=LOWROOM=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sfifo_sync;

   localparam int DW = 24;
   localparam int AW = 4;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fails;
   logic [DW-1:0] q_model [$];

   sfifo_sync_if #(.DW(DW), .AW(AW)) u_if ();

   sfifo_sync #(.DW(DW), .AW(AW), .HEADROOM(2), .LOWROOM(2)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_empty"},   32'(u_if.empty),    32'd1);
      check({tag, "_alempty"}, 32'(u_if.alEmpty),  32'd1);
      check({tag, "_full"},    32'(u_if.full),     32'd0);
      check({tag, "_alfull"},  32'(u_if.alFull),   32'd0);
      check({tag, "_count"},   32'(u_if.count),    32'd0);
      check({tag, "_vld"},     32'(u_if.vld),      32'd0);
      check({tag, "_dout"},    32'(u_if.data_out), 32'd0);
`ifdef SFIFO_SYNC_ERR_EN
      check({tag, "_ovf"},     32'(u_if.ovf),      32'd0);
      check({tag, "_udf"},     32'(u_if.udf),      32'd0);
`endif
   endtask

   initial begin
      logic [DW-1:0] exp_d;
      int occ;
      int pu;
      int po;
      n_checks     = 0;
      n_fails      = 0;
      rst_n        = 1'b0;
      u_if.push    = 1'b0;
      u_if.pop     = 1'b0;
      u_if.data_in = '0;
`ifdef SFIFO_SYNC_ERR_EN
      u_if.err_clr = 1'b0;
`endif
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check_reset_state("rst");

      // Fill 16, then one push while full.
      for (int i = 1; i <= 16; i++) begin
         u_if.push = 1'b1; u_if.data_in = DW'(i);
         tick();
         check("fill_count",  32'(u_if.count),  32'(i));
         check("fill_alfull", 32'(u_if.alFull), (i >= 14) ? 32'd1 : 32'd0);
         check("fill_full",   32'(u_if.full),   (i == 16) ? 32'd1 : 32'd0);
         check("fill_empty",  32'(u_if.empty),  32'd0);
      end
      u_if.data_in = 24'hFFFFFF;
      tick();
      u_if.push = 1'b0;
      check("ovf_push_count", 32'(u_if.count), 32'd16);
      check("ovf_push_full",  32'(u_if.full),  32'd1);

      // Drain 16 in order.
      for (int i = 1; i <= 16; i++) begin
         u_if.pop = 1'b1;
         tick();
         check("drain_vld",     32'(u_if.vld),      32'd1);
         check("drain_data",    32'(u_if.data_out), 32'(i));
         check("drain_count",   32'(u_if.count),    32'(16 - i));
         check("drain_alempty", 32'(u_if.alEmpty),  (16 - i <= 2) ? 32'd1 : 32'd0);
         check("drain_empty",   32'(u_if.empty),    (i == 16) ? 32'd1 : 32'd0);
      end
      u_if.pop = 1'b1;
      tick();
      u_if.pop = 1'b0;
      check("udf_pop_vld",  32'(u_if.vld),      32'd0);
      check("udf_pop_hold", 32'(u_if.data_out), 32'h10);
      check("udf_pop_cnt",  32'(u_if.count),    32'd0);
`ifdef SFIFO_SYNC_ERR_EN
      check("udf_set",      32'(u_if.udf),      32'd1);
      tick();
      check("udf_sticky",   32'(u_if.udf),      32'd1);
`endif

      // Full FIFO with simultaneous push and pop.
      for (int i = 1; i <= 16; i++) begin
         u_if.push = 1'b1; u_if.data_in = DW'(32'h100 + i);
         tick();
      end
      u_if.data_in = 24'h555555; u_if.pop = 1'b1;
      tick();
      u_if.push = 1'b0; u_if.pop = 1'b0;
      check("fullpp_count", 32'(u_if.count),    32'd15);
      check("fullpp_full",  32'(u_if.full),     32'd0);
      check("fullpp_vld",   32'(u_if.vld),      32'd1);
      check("fullpp_data",  32'(u_if.data_out), 32'h101);
`ifdef SFIFO_SYNC_ERR_EN
      check("fullpp_ovf",   32'(u_if.ovf),      32'd1);
      u_if.push = 1'b1; u_if.data_in = 24'h777777;
      tick();
      check("refill_count", 32'(u_if.count),    32'd16);
      u_if.err_clr = 1'b1;
      tick();
      check("setclr_ovf",   32'(u_if.ovf),      32'd1);
      u_if.push = 1'b0;
      tick();
      u_if.err_clr = 1'b0;
      check("clr_ovf",      32'(u_if.ovf),      32'd0);
      check("clr_udf",      32'(u_if.udf),      32'd0);
      u_if.pop = 1'b1;
      tick();
      u_if.pop = 1'b0;
      check("refill_pop",   32'(u_if.data_out), 32'h102);
      for (int i = 3; i <= 16; i++) q_model.push_back(DW'(32'h100 + i));
      q_model.push_back(24'h777777);
`else
      for (int i = 2; i <= 16; i++) q_model.push_back(DW'(32'h100 + i));
`endif
      while (q_model.size() > 0) begin
         exp_d = q_model.pop_front();
         u_if.pop = 1'b1;
         tick();
         check("pp_drain_data", 32'(u_if.data_out), 32'(exp_d));
      end
      u_if.pop = 1'b0;
      tick();
      check("pp_drain_empty", 32'(u_if.empty), 32'd1);

      // Empty FIFO with simultaneous push and pop: no bypass.
      u_if.push = 1'b1; u_if.pop = 1'b1; u_if.data_in = 24'hABCDEF;
      tick();
      u_if.push = 1'b0;
      check("emptypp_count", 32'(u_if.count), 32'd1);
      check("emptypp_vld",   32'(u_if.vld),   32'd0);
      check("emptypp_empty", 32'(u_if.empty), 32'd0);
      tick();
      u_if.pop = 1'b0;
      check("emptypp_vld2",  32'(u_if.vld),      32'd1);
      check("emptypp_data",  32'(u_if.data_out), 32'hABCDEF);
      check("emptypp_cnt2",  32'(u_if.count),    32'd0);

      // Random traffic across pointer wrap, occupancy held in 3..10.
      for (int i = 0; i < 5; i++) begin
         exp_d = DW'($urandom);
         u_if.push = 1'b1; u_if.data_in = exp_d;
         q_model.push_back(exp_d);
         tick();
      end
      u_if.push = 1'b0;
      for (int c = 0; c < 40; c++) begin
         occ = q_model.size();
         pu  = int'($urandom_range(1, 0));
         po  = int'($urandom_range(1, 0));
         if (occ + pu - po > 10) pu = 0;
         if (occ + pu - po < 3)  po = 0;
         exp_d = DW'($urandom);
         u_if.push = pu[0]; u_if.pop = po[0]; u_if.data_in = exp_d;
         tick();
         if (po == 1) begin
            check("wrap_vld",  32'(u_if.vld),      32'd1);
            check("wrap_data", 32'(u_if.data_out), 32'(q_model.pop_front()));
         end else begin
            check("wrap_novld", 32'(u_if.vld), 32'd0);
         end
         if (pu == 1) q_model.push_back(exp_d);
         check("wrap_count", 32'(u_if.count), 32'(q_model.size()));
      end
      u_if.push = 1'b0;
      while (q_model.size() > 0) begin
         u_if.pop = 1'b1;
         tick();
         check("wrap_drain", 32'(u_if.data_out), 32'(q_model.pop_front()));
      end
      u_if.pop = 1'b0;
      tick();

      // Asynchronous reset in the middle of a burst.
`ifdef SFIFO_SYNC_ERR_EN
      u_if.pop = 1'b1;
      tick();
      u_if.pop = 1'b0;
      check("pre_rst_udf", 32'(u_if.udf), 32'd1);
`endif
      for (int i = 0; i < 15; i++) begin
         u_if.push = 1'b1; u_if.data_in = DW'(32'h200 + i);
         tick();
      end
      u_if.pop = 1'b1;
      tick();
      check("pre_rst_alfull", 32'(u_if.alFull), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_state("async_rst");
      u_if.push = 1'b0; u_if.pop = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check_reset_state("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

`default_nettype wire
